alu_mdu: RTL
============

# alu_mdu

Iterative multiply/divide unit that extends the single-cycle ALU with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the combinational ALU in the execute stage. It accepts one operation per valid/ready handshake and computes one bit per clock. It returns the result plus an opaque tag through a second valid/ready handshake. A kill input lets the core abort on flush.

## Interface
- `DW`, 32: operand/result width; any even value ≥ 4.
- `TW`, 5: width of pass-through tag (e.g. rd index).
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: unit can accept; high only in IDLE.
- `in_op`  in  3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_op1`  in  DW: rs1 (multiplicand / dividend).
- `in_op2`  in  DW: rs2 (multiplier / divisor).
- `in_tag`  in  TW: captured on accept, returned unchanged.
- `kill`  in  1: abort the in-flight operation.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out_res`  out  DW: result.
- `out_tag`  out  TW: tag of the operation.
- `busy`  out  1: state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid` with no `kill`, latch op, the operand magnitudes, the sign flags and the tag.
  - Special cases go directly to DONE. All others go to CALC with counter = DW-1.
- Signedness:
  - op1 is signed for MUL, MULH, MULHSU, DIV and REM.
  - op2 is signed for MUL, MULH, DIV and REM.
  - MUL's low word is sign-agnostic.
  - The core works on absolute values.
- Multiply: shift-add over a 2·DW-bit accumulator, one multiplier bit per cycle.
  - The final product is negated when exactly one operand is negative (and signed).
  - MUL returns bits [DW-1:0]; MULH/MULHSU/MULHU return bits [2DW-1:DW].
- Divide: restoring, one quotient bit per cycle on unsigned magnitudes.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no CALC cycles:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1 = 1<<(DW-1), op2 = all-ones, DIV/REM): DIV returns op1, REM returns 0.
- CALC:
  - Decrement the counter each cycle.
  - When the counter is 0, apply sign fix-up, register `out_res` and go to DONE.
- DONE:
  - `out_valid`=1; `out_res`/`out_tag` stable until handshake.
  - On `out_ready`, return to IDLE. A new request cannot be accepted in the same cycle.
- Kill:
  - In CALC or DONE: go to IDLE next edge, drop the result, `out_valid` low next cycle.
  - In IDLE: blocks acceptance that cycle.
  - Kill wins over `out_ready` when both are high in DONE.
- Reset mid-operation: immediately returns to IDLE and discards all state.

## Timing
- Reset values:
  - state IDLE; `in_ready`=1; `out_valid`=0; `busy`=0.
  - `out_res`=0; `out_tag`=0; counter=0.
- Normal latency: accept edge E0.
  - CALC occupies DW cycles.
  - `out_valid` rises after edge E0+DW and is high in the (DW+1)th cycle after the accept cycle.
- Special-case latency: `out_valid` is high in the cycle after accept.
- Throughput: one op per DW+2 cycles minimum (IDLE→CALC…→DONE→IDLE).
- Outputs are registered. `in_ready`, `busy` and `out_valid` are decoded from state only, never from inputs.
- Backpressure: DONE holds indefinitely while `out_ready`=0.

## Test plan
- Multiply, DW=32:
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - Each: `out_valid` exactly 33 cycles after the accept cycle.
- Divide:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - Tag 0x1A returned on `out_tag`.
- Special cases:
  - DIV x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - Each: `out_valid` 1 cycle after accept.
- Backpressure and kill:
  - Hold `out_ready`=0 for 10 cycles in DONE → result stable, `in_ready`=0.
  - Pulse `kill` at CALC cycle 5 → IDLE next cycle, no `out_valid`.
  - Next op completes correctly.
- Reset:
  - Deassert `rst_n` asynchronously mid-CALC → outputs take reset values before the next edge.
  - After release, a new MULHU completes correctly.
- Random: 10k random ops/operands with random `out_ready` stalls, checked against a reference model; DW=8 variant exhaustive for DIV/REM.

Source files
------------

// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per clock, valid/ready on both sides.
// Divide-by-zero and signed overflow are resolved at accept time without iterating.
module alu_mdu #(
  parameter int DW = 32,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [DW-1:0] in_op1,
  input  logic [DW-1:0] in_op2,
  input  logic [TW-1:0] in_tag,
  input  logic          kill,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [TW-1:0] out_tag,
  output logic          busy
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]      op;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] acc, acc_nxt;
  logic [DW-1:0]   opnd;
  logic            neg_q, neg_r;

  logic            accept, s1_en, s2_en, in_s1, in_s2, div0, ovf, special;
  logic [DW-1:0]   mag1, mag2, spec_res;

  assign accept    = (state == IDLE) && in_valid && !kill;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Operand decode: signedness per funct3, magnitudes, and the two no-iteration cases
  always_comb begin
    s1_en    = 1'b0;
    s2_en    = 1'b0;
    spec_res = '0;
    case (in_op)
      3'd0, 3'd1, 3'd4, 3'd6: begin s1_en = 1'b1; s2_en = 1'b1; end
      3'd2:                   s1_en = 1'b1;
      default:                ;
    endcase
    in_s1   = s1_en & in_op1[DW-1];
    in_s2   = s2_en & in_op2[DW-1];
    mag1    = in_s1 ? -in_op1 : in_op1;
    mag2    = in_s2 ? -in_op2 : in_op2;
    div0    = in_op[2] && (in_op2 == '0);
    ovf     = (in_op == 3'd4 || in_op == 3'd6) &&
              (in_op1 == {1'b1, {(DW-1){1'b0}}}) && (in_op2 == '1);
    special = div0 | ovf;
    if (div0)
      spec_res = in_op[1] ? in_op1 : '1;
    else if (ovf)
      spec_res = in_op[1] ? '0 : in_op1;
  end

  logic [DW:0]   mul_sum, rem_sh, diff;
  logic          qbit;
  logic [2*DW-1:0] prod;
  logic [DW-1:0] quo, rem, fin_res;

  // One iteration step; acc is {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = acc[2*DW-1:DW-1];
    diff    = rem_sh - {1'b0, opnd};
    qbit    = ~diff[DW];
    if (op[2])
      acc_nxt = {(qbit ? diff[DW-1:0] : rem_sh[DW-1:0]), acc[DW-2:0], qbit};
    else
      acc_nxt = {mul_sum, acc[DW-1:1]};
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[DW-1:0] : acc_nxt[DW-1:0];
    rem  = neg_r ? -acc_nxt[2*DW-1:DW] : acc_nxt[2*DW-1:DW];
    if (op[2])
      fin_res = op[1] ? rem : quo;
    else
      fin_res = (op == 3'd0) ? prod[DW-1:0] : prod[2*DW-1:DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (kill) state_nxt = IDLE;
            else if (cnt == '0) state_nxt = DONE;
      DONE: if (kill || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= '0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      out_res <= '0;
      out_tag <= '0;
    end else if (accept) begin
      op      <= in_op;
      out_tag <= in_tag;
      neg_q   <= in_s1 ^ in_s2;
      neg_r   <= in_s1;
      if (special) begin
        cnt     <= '0;
        out_res <= spec_res;
      end else begin
        cnt  <= CW'(DW-1);
        // Multiply keeps the multiplicand aside; divide keeps the divisor aside
        acc  <= {{DW{1'b0}}, (in_op[2] ? mag1 : mag2)};
        opnd <= in_op[2] ? mag2 : mag1;
      end
    end else if (state == CALC && !kill) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        out_res <= fin_res;
    end
  end

endmodule
